// File: rtl/modu_ctrl_pkg.sv
// Shared definitions for the module-output command arbiter: network command
// opcodes, the packed command layout and the arbiter FSM state encoding.
package modu_ctrl_pkg;

    localparam int CMD_W = 12;
    localparam int OP_W  = 3;
    localparam int PKT_W = 4;
    localparam int IDX_W = 5;

    localparam logic [OP_W-1:0] OP_SET = 3'b001;
    localparam logic [OP_W-1:0] OP_CLR = 3'b010;
    localparam logic [OP_W-1:0] OP_TGL = 3'b011;

    // Field order matches the wire format: [11:9] opcode, [8:5] packet id, [4:0] bit index.
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [PKT_W-1:0] pkt;
        logic [IDX_W-1:0] idx;
    } net_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_t;

    // A command is applied only for a known opcode aimed at an existing output bit.
    function automatic logic cmd_is_valid(input net_cmd_t cmd, input int num_out);
        logic op_ok;
        op_ok = (cmd.op == OP_SET) || (cmd.op == OP_CLR) || (cmd.op == OP_TGL);
        return op_ok && (int'(cmd.idx) < num_out);
    endfunction

endpackage

// File: rtl/modu_cmd_arbiter_fifo.sv
// Small synchronous FIFO holding network commands until the arbiter takes them.
// A freshly written entry becomes readable one cycle after its write edge, so the
// read side sees a registered empty indication.
module cmd_fifo #(
    parameter int  WIDTH = 12,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             rd_avail,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    assign full      = (level == LVL_W'(DEPTH));
    assign do_push   = push && !full;
    assign do_pop    = pop && (level != '0);
    assign head_data = mem[rd_ptr];
    assign rd_avail  = (level != '0) && !empty_q;

    // Pointer, occupancy and delayed-empty bookkeeping.
    always_ff @(posedge clock_in) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level   <= level + LVL_W'(do_push) - LVL_W'(do_pop);
            empty_q <= (level == '0);
        end
    end

    // Entry storage.
    always_ff @(posedge clock_in) begin
        // NOTE: storage is deliberately left out of reset; validity is carried by the
        // pointers and level, and an unreset array maps onto plain RAM.
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/modu_cmd_arbiter.sv
// Owner of the module output register. Arbitrates its single write port between
// CPU module-write instructions and buffered network commands, acknowledging each
// network command with a valid/ready handshake. A bounded CPU winning streak keeps
// a waiting network command from starving.
module modu_cmd_arbiter #(
    parameter int NUM_OUT        = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int CPU_STREAK_MAX = 3
) (
    input  logic                          clock_in,
    input  logic                          reset,
    input  logic                          cpu_wr,
    input  logic [4:0]                    cpu_idx,
    input  logic                          cpu_val,
    output logic                          cpu_stall,
    input  logic                          net_valid,
    output logic                          net_ready,
    input  logic [11:0]                   net_cmd,
    output logic                          ack_valid,
    input  logic                          ack_ready,
    output logic [3:0]                    ack_pkt,
    output logic                          ack_ok,
    output logic [NUM_OUT-1:0]            modu,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_count
);

    import modu_ctrl_pkg::*;

    localparam int STREAK_W = $clog2(CPU_STREAK_MAX + 1);

    arb_state_t           state;
    arb_state_t           state_next;
    net_cmd_t             cmd_q;
    logic [CMD_W-1:0]     fifo_head;
    logic                 fifo_full;
    logic                 fifo_rd_avail;
    logic                 fifo_pop;
    logic                 cmd_ok;
    logic                 cpu_win;
    logic                 cpu_grant;
    logic                 net_apply;
    logic                 cmd_done;
    logic [STREAK_W-1:0]  streak;
    logic [NUM_OUT-1:0]   modu_next;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clock_in  (clock_in),
        .reset     (reset),
        .push      (net_valid),
        .push_data (net_cmd),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .rd_avail  (fifo_rd_avail),
        .level     (fifo_level)
    );

    assign net_ready = !fifo_full;
    assign ack_valid = (state == ST_ACK);
    assign cmd_ok    = cmd_is_valid(cmd_q, NUM_OUT);
    assign cpu_grant = cpu_wr && !cpu_stall;

    // Next-state and write-port arbitration.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_next = state;
        fifo_pop   = 1'b0;
        cpu_win    = 1'b0;
        net_apply  = 1'b0;
        cmd_done   = 1'b0;
        cpu_stall  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (fifo_rd_avail) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!cmd_ok) begin
                    cmd_done   = 1'b1;
                    state_next = ST_ACK;
                end else if (cpu_wr && (int'(streak) < CPU_STREAK_MAX)) begin
                    cpu_win = 1'b1;
                end else begin
                    net_apply  = 1'b1;
                    cpu_stall  = cpu_wr;
                    cmd_done   = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                if (ack_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output register update from whichever requester owns the write port this cycle.
    always_comb begin
        modu_next = modu;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (net_apply && (int'(cmd_q.idx) == i)) begin
                case (cmd_q.op)
                    OP_SET:  modu_next[i] = 1'b1;
                    OP_CLR:  modu_next[i] = 1'b0;
                    OP_TGL:  modu_next[i] = ~modu[i];
                    default: modu_next[i] = modu[i];
                endcase
            end
            if (cpu_grant && (int'(cpu_idx) == i)) modu_next[i] = cpu_val;
        end
    end

    // FSM state register.
    always_ff @(posedge clock_in) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Command register, streak, output register, acknowledge fields and drop counter.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            cmd_q      <= '0;
            streak     <= '0;
            modu       <= '0;
            ack_pkt    <= '0;
            ack_ok     <= 1'b0;
            drop_count <= '0;
        end else begin
            if (fifo_pop) cmd_q <= net_cmd_t'(fifo_head);
            streak <= cpu_win ? streak + STREAK_W'(1) : '0;
            modu   <= modu_next;
            if (cmd_done) begin
                ack_pkt <= cmd_q.pkt;
                ack_ok  <= cmd_ok;
                if (!cmd_ok && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_modu_cmd_arbiter.sv
// Self-checking bench for modu_cmd_arbiter: directed scenarios with fixed expected
// values plus a randomized phase, all watched by a transaction-level model.
module tb_modu_cmd_arbiter;

    logic        clock_in;
    logic        reset;
    logic        cpu_wr;
    logic [4:0]  cpu_idx;
    logic        cpu_val;
    logic        cpu_stall;
    logic        net_valid;
    logic        net_ready;
    logic [11:0] net_cmd;
    logic        ack_valid;
    logic        ack_ready;
    logic [3:0]  ack_pkt;
    logic        ack_ok;
    logic [7:0]  modu;
    logic [2:0]  fifo_level;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    modu_cmd_arbiter dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .cpu_wr     (cpu_wr),
        .cpu_idx    (cpu_idx),
        .cpu_val    (cpu_val),
        .cpu_stall  (cpu_stall),
        .net_valid  (net_valid),
        .net_ready  (net_ready),
        .net_cmd    (net_cmd),
        .ack_valid  (ack_valid),
        .ack_ready  (ack_ready),
        .ack_pkt    (ack_pkt),
        .ack_ok     (ack_ok),
        .modu       (modu),
        .fifo_level (fifo_level),
        .drop_count (drop_count)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    function automatic logic [11:0] mk(input int unsigned op, input int unsigned pkt,
                                       input int unsigned idx);
        return {3'(op), 4'(pkt), 5'(idx)};
    endfunction

    task automatic send(input logic [11:0] c);
        net_valid = 1'b1;
        net_cmd   = c;
        tick();
        net_valid = 1'b0;
    endtask

    task automatic wait_ack(input int budget);
        int n = 0;
        while (!ack_valid && n < budget) begin
            tick();
            n++;
        end
        check("ack_timeout", ack_valid, 1);
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic [3:0] pkt;
        logic       ok;
        logic [2:0] op;
        logic [4:0] idx;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [7:0]  exp_modu  = 8'h00;
    int          exp_drops = 0;
    bit          model_on  = 0;
    bit          ack_seen  = 0;
    bit          pend_cpu  = 0;
    bit          stall_prev = 0;
    int          pend_idx  = 0;
    logic        pend_val  = 1'b0;
    logic        new_ack;

    // Inputs change just after posedge, so at negedge they hold the values the next
    // edge will sample; DUT outputs reflect everything up to the previous edge.
    always @(negedge clock_in) begin
        if (model_on) begin
            if (pend_cpu && pend_idx < 8) exp_modu[pend_idx] = pend_val;
            new_ack = ack_valid && !ack_seen;
            if (stall_prev) check("stall_then_ack", new_ack, 1);
            if (new_ack) begin
                if (exp_q.size() == 0) begin
                    check("ack_without_cmd", 0, 1);
                end else begin
                    e = exp_q[0];
                    check("m_ack_pkt", ack_pkt, e.pkt);
                    check("m_ack_ok", ack_ok, e.ok);
                    if (e.ok) begin
                        case (e.op)
                            3'd1: exp_modu[e.idx] = 1'b1;
                            3'd2: exp_modu[e.idx] = 1'b0;
                            default: exp_modu[e.idx] = ~exp_modu[e.idx];
                        endcase
                    end else if (exp_drops != 255) begin
                        exp_drops++;
                    end
                    check("m_drop_count", drop_count, exp_drops);
                end
            end
            check("m_modu", modu, exp_modu);
            if (cpu_stall) check("stall_without_req", cpu_wr, 1);

            pend_cpu   = cpu_wr && !cpu_stall;
            pend_idx   = int'(cpu_idx);
            pend_val   = cpu_val;
            stall_prev = cpu_stall;
            if (net_valid && net_ready) begin
                e.op  = net_cmd[11:9];
                e.pkt = net_cmd[8:5];
                e.idx = net_cmd[4:0];
                e.ok  = (e.op >= 3'd1 && e.op <= 3'd3) && (e.idx < 5'd8);
                exp_q.push_back(e);
            end
            if (ack_valid && ack_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                ack_seen = 0;
            end else if (ack_valid) begin
                ack_seen = 1;
            end

            if (reset) begin
                exp_q.delete();
                exp_modu   = 8'h00;
                exp_drops  = 0;
                ack_seen   = 0;
                pend_cpu   = 0;
                stall_prev = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [11:0] burst [5];
        logic [3:0]  burst_pkt [5];

        reset = 1'b1; cpu_wr = 1'b0; cpu_idx = '0; cpu_val = 1'b0;
        net_valid = 1'b0; net_cmd = '0; ack_ready = 1'b0;
        tick();
        model_on = 1;
        tick();
        check("rst_modu", modu, 8'h00);
        check("rst_level", fifo_level, 0);
        check("rst_ack_valid", ack_valid, 0);
        check("rst_ack_pkt", ack_pkt, 0);
        check("rst_ack_ok", ack_ok, 0);
        check("rst_drops", drop_count, 0);
        check("rst_stall", cpu_stall, 0);
        check("rst_ready", net_ready, 1);
        reset = 1'b0;
        tick();

        // Basic SET with three-edge latency.
        ack_ready = 1'b1;
        send(12'b001_0101_00011);          // accepted at edge t
        check("lat_level", fifo_level, 1);
        tick();                            // t+1
        check("lat_t1_modu", modu, 8'h00);
        tick();                            // t+2
        check("lat_t2_modu", modu, 8'h00);
        check("lat_t2_ack", ack_valid, 0);
        tick();                            // t+3
        check("lat_t3_modu", modu, 8'h08);
        check("lat_t3_ack", ack_valid, 1);
        check("lat_t3_pkt", ack_pkt, 4'h5);
        check("lat_t3_ok", ack_ok, 1);
        tick();
        check("lat_t4_ack", ack_valid, 0);

        // Bad opcode and bad index are dropped.
        send(mk(7, 1, 0));
        wait_ack(20);
        check("drop_op_ok", ack_ok, 0);
        check("drop_op_pkt", ack_pkt, 1);
        tick();
        send(mk(1, 2, 9));
        wait_ack(20);
        check("drop_idx_ok", ack_ok, 0);
        check("drop_idx_pkt", ack_pkt, 2);
        tick();
        check("drop_modu", modu, 8'h08);
        check("drop_count", drop_count, 2);

        // CPU wins three REQ cycles, then the waiting network SET takes the port.
        cpu_wr = 1'b1; cpu_idx = 5'd0; cpu_val = 1'b1;
        check("streak_pre_stall", cpu_stall, 0);
        send(mk(1, 3, 7));                 // edge t
        for (int i = 0; i < 6; i++) begin
            check("streak_stall", cpu_stall, (i == 5));
            check("streak_bit7", modu[7], 0);
            tick();
        end
        check("streak_modu", modu, 8'h89);
        check("streak_ack", ack_valid, 1);
        check("streak_pkt", ack_pkt, 3);
        check("streak_resume", cpu_stall, 0);
        tick();
        cpu_wr = 1'b0;
        tick();

        // Hold one command in ACK, then fill the FIFO and overflow it by one.
        ack_ready = 1'b0;
        send(mk(2, 7, 3));
        wait_ack(20);
        burst[0] = mk(1, 8, 1);  burst_pkt[0] = 4'd8;
        burst[1] = mk(1, 9, 2);  burst_pkt[1] = 4'd9;
        burst[2] = mk(2, 10, 1); burst_pkt[2] = 4'd10;
        burst[3] = mk(3, 11, 4); burst_pkt[3] = 4'd11;
        burst[4] = mk(1, 12, 6); burst_pkt[4] = 4'd12;
        for (int i = 0; i < 5; i++) begin
            check("fill_level", fifo_level, i);
            check("fill_ready", net_ready, (i < 4));
            net_valid = 1'b1;
            net_cmd   = burst[i];
            tick();
        end
        net_valid = 1'b0;
        check("full_level", fifo_level, 4);
        check("full_ready", net_ready, 0);
        ack_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            wait_ack(20);
            check("drain_pkt", ack_pkt, burst_pkt[i]);
            tick();
        end
        check("drain_modu", modu, 8'h95);
        check("drain_level", fifo_level, 0);

        // Clear then toggle bit 2 twice.
        send(mk(2, 1, 2));
        wait_ack(20);
        check("tgl_clr", modu[2], 0);
        tick();
        send(mk(3, 2, 2));
        wait_ack(20);
        check("tgl_1", modu[2], 1);
        tick();
        send(mk(3, 3, 2));
        wait_ack(20);
        check("tgl_2", modu[2], 0);
        check("tgl_modu", modu, 8'h91);
        tick();

        // Reset while an acknowledge is pending and the FIFO holds an entry.
        ack_ready = 1'b0;
        send(mk(1, 9, 5));
        send(mk(1, 10, 6));
        wait_ack(20);
        check("prerst_level", fifo_level, 1);
        reset = 1'b1;
        tick();
        check("midrst_ack", ack_valid, 0);
        check("midrst_level", fifo_level, 0);
        check("midrst_modu", modu, 8'h00);
        check("midrst_drops", drop_count, 0);
        reset = 1'b0;
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 299) == 0);
            cpu_wr    = ($urandom_range(0, 1) == 1);
            cpu_idx   = 5'($urandom_range(0, 9));
            cpu_val   = 1'($urandom_range(0, 1));
            net_valid = ($urandom_range(0, 9) < 4);
            net_cmd   = mk($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 9));
            ack_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        // Quiesce and confirm everything accepted was acknowledged.
        reset = 1'b0; cpu_wr = 1'b0; net_valid = 1'b0; ack_ready = 1'b1;
        repeat (40) tick();
        check("end_level", fifo_level, 0);
        check("end_ack", ack_valid, 0);
        check("end_outstanding", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
